// File: rtl/prog_fir_coeff_loader_if.sv
// Port-A read bus between the coefficient loader and the coefficient RAM.
interface prog_fir_coeff_loader_if #(
    parameter int ADDR_W = 10
);
    logic              bram_en_a;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_rd_data;

    modport master (output bram_en_a, output bram_addr, input bram_rd_data);
    modport slave  (input bram_en_a, input bram_addr, output bram_rd_data);
endinterface

// File: rtl/prog_fir_coeff_loader.sv
// Fetches a FIR coefficient set into a shadow bank and swaps it into the
// active bank only on a stream frame boundary.
module prog_fir_coeff_loader #(
    parameter int N_TAPS     = 26,
    parameter int COEFF_W    = 16,
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_req,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic                        frame_sync,
    prog_fir_coeff_loader_if.master     ram,
    output logic [N_TAPS*COEFF_W-1:0]   coeffs,
    output logic                        coeff_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        load_err
);
    localparam int NWORDS = N_TAPS / 2;
    localparam int WORD_W = 2 * COEFF_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, PEND} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   base_reg;
    logic [CNT_W-1:0]    issue_cnt_reg;
    logic [CNT_W-1:0]    capture_cnt_reg;
    logic [RD_LATENCY-1:0] vld_reg;
    logic [WORD_W-1:0]   shadow_reg [NWORDS];
    logic [WORD_W-1:0]   active_reg [NWORDS];
    logic                done_reg, coeff_valid_reg, load_err_reg;

    logic capture, last_issue, last_capture, accept, swap;

    assign capture      = vld_reg[RD_LATENCY-1];
    assign last_issue   = (issue_cnt_reg == CNT_W'(NWORDS - 1));
    assign last_capture = capture && (capture_cnt_reg == CNT_W'(NWORDS - 1));
    assign accept       = (state_reg == IDLE) && load_req;
    assign swap         = (state_reg == PEND) && frame_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // A frame_sync during the final capture is ignored: PEND is entered only afterwards.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load_req)     state_next = READ;
            READ:    if (last_issue)   state_next = DRAIN;
            DRAIN:   if (last_capture) state_next = PEND;
            PEND:    if (frame_sync)   state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        ram.bram_en_a = 1'b0;
        ram.bram_addr = '0;
        busy          = (state_reg != IDLE);
        if (state_reg == READ) begin
            ram.bram_en_a = 1'b1;
            ram.bram_addr = base_reg + ADDR_W'(issue_cnt_reg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg        <= '0;
            issue_cnt_reg   <= '0;
            capture_cnt_reg <= '0;
            vld_reg         <= '0;
            done_reg        <= 1'b0;
            coeff_valid_reg <= 1'b0;
            load_err_reg    <= 1'b0;
        end else begin
            if (accept) begin
                base_reg        <= base_addr;
                issue_cnt_reg   <= '0;
                capture_cnt_reg <= '0;
            end else begin
                if (state_reg == READ) issue_cnt_reg <= issue_cnt_reg + 1'b1;
                if (capture)           capture_cnt_reg <= capture_cnt_reg + 1'b1;
            end
            vld_reg      <= RD_LATENCY'({vld_reg, ram.bram_en_a});
            done_reg     <= swap;
            load_err_reg <= load_req && (state_reg != IDLE);
            if (swap) coeff_valid_reg <= 1'b1;
        end
    end

    // Each RAM word already holds tap 2j in its low half, so words copy straight across.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                if (capture && (capture_cnt_reg == CNT_W'(i))) shadow_reg[i] <= ram.bram_rd_data;
                if (swap) active_reg[i] <= shadow_reg[i];
            end
        end
    end

    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_flatten
        assign coeffs[gi*WORD_W +: WORD_W] = active_reg[gi];
    end

    assign done        = done_reg;
    assign coeff_valid = coeff_valid_reg;
    assign load_err    = load_err_reg;
endmodule
